if_id_stage: RTL

- Fetch/decode boundary stage. It sits directly downstream of the instruction fetch stage and upstream of decode.
- Buffers fetched {PC, PCPlus4, Inst} in a 2-entry skid FIFO with a valid/ready handshake on both sides.
- Applies branch flush and presents registered pre-decoded ARM instruction fields to decode.
- Fetch uses in_ready to hold its PC while the stage is full.

---
 rtl/if_id_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/if_id_stage.sv
// if_id_stage: fetch/decode boundary with a 2-entry skid FIFO and registered
// ARM pre-decode fields. The optional performance counters are built when
// IF_ID_PERF_EN is defined. Without it, both perf ports read zero and no
// counter flops exist.
module if_id_stage #(
    parameter int unsigned     ADDR_W   = 32,
    parameter int unsigned     INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = 32'hE1A00000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [ADDR_W-1:0] in_pcplus4,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_pcplus4,
    output logic [INST_W-1:0] out_inst,
    output logic [3:0]        out_cond,
    output logic [1:0]        out_op,
    output logic [5:0]        out_funct,
    output logic [3:0]        out_rn,
    output logic [3:0]        out_rd,
    output logic              out_cond_al,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    // Storage and pointer state
    logic [ADDR_W-1:0] mem_pc     [DEPTH];
    logic [ADDR_W-1:0] mem_pcplus4[DEPTH];
    logic [INST_W-1:0] mem_inst   [DEPTH];
    logic              head_q, tail_q;
    logic [CNT_W-1:0]  count_q;

    // Next-state signals
    logic              push, pop;
    logic              head_n, tail_n;
    logic [CNT_W-1:0]  count_n;
    logic              valid_n;
    logic [ADDR_W-1:0] pc_n, pcplus4_n;
    logic [INST_W-1:0] inst_n;

    // Handshake decode and pointer/count update; the head entry after the edge
    // may be the word written this cycle, so it is forwarded from the inputs.
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        head_n    = head_q;
        tail_n    = tail_q;
        count_n   = count_q;
        valid_n   = 1'b0;
        pc_n      = out_pc;
        pcplus4_n = out_pcplus4;
        inst_n    = NOP_INST;

        push = in_valid && (count_q != CNT_W'(DEPTH)) && !flush;
        pop  = (count_q != CNT_W'(0)) && out_ready && !flush;

        if (flush) begin
            head_n  = 1'b0;
            tail_n  = 1'b0;
            count_n = '0;
        end else begin
            head_n  = pop  ? ~head_q : head_q;
            tail_n  = push ? ~tail_q : tail_q;
            count_n = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        valid_n = (count_n != CNT_W'(0));
        if (valid_n) begin
            if (push && (tail_q == head_n)) begin
                pc_n      = in_pc;
                pcplus4_n = in_pcplus4;
                inst_n    = in_inst;
            end else begin
                pc_n      = mem_pc[head_n];
                pcplus4_n = mem_pcplus4[head_n];
                inst_n    = mem_inst[head_n];
            end
        end
    end

    // FIFO storage write; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[tail_q]      <= in_pc;
            mem_pcplus4[tail_q] <= in_pcplus4;
            mem_inst[tail_q]    <= in_inst;
        end
    end

    // Pointer, count and registered output update
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            count_q     <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_pcplus4 <= '0;
            out_inst    <= NOP_INST;
            out_cond    <= NOP_INST[31:28];
            out_op      <= NOP_INST[27:26];
            out_funct   <= NOP_INST[25:20];
            out_rn      <= NOP_INST[19:16];
            out_rd      <= NOP_INST[15:12];
            out_cond_al <= (NOP_INST[31:28] == 4'hE);
        end else begin
            head_q      <= head_n;
            tail_q      <= tail_n;
            count_q     <= count_n;
            in_ready    <= (count_n != CNT_W'(DEPTH));
            out_valid   <= valid_n;
            out_pc      <= pc_n;
            out_pcplus4 <= pcplus4_n;
            out_inst    <= inst_n;
            out_cond    <= inst_n[31:28];
            out_op      <= inst_n[27:26];
            out_funct   <= inst_n[25:20];
            out_rn      <= inst_n[19:16];
            out_rd      <= inst_n[15:12];
            out_cond_al <= (inst_n[31:28] == 4'hE);
        end
    end

`ifdef IF_ID_PERF_EN
    // Saturating stall and flush event counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (in_valid && !in_ready && !flush && (perf_stall_cnt != 32'hFFFF_FFFF))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush && (perf_flush_cnt != 32'hFFFF_FFFF))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule
